// File: rtl/mem_ctrl_pkg.sv
// Shared widths, constants and state encoding for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_LEN  = 32;
  localparam int INSTR_LEN = 32;
  localparam int BYTE_LEN  = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [ADDR_LEN-1:0] IO_ADDR = 32'h30000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IC_READ  = 3'd1,
    LS_READ  = 3'd2,
    LS_WRITE = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Anything other than 1 or 2 bytes moves a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating ICache fetches and LSB loads/stores;
// each result is returned with a one-cycle success pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_LEN,
  parameter logic [ADDR_W-1:0] IO_ADDR = mem_ctrl_pkg::IO_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [BYTE_LEN-1:0]  mem_din,
  output logic [BYTE_LEN-1:0]  mem_dout,
  output logic [ADDR_W-1:0]    mem_a,
  output logic                 mem_wr,
  input  logic                 io_buffer_full,
  input  logic                 clr,
  input  logic                 ic_enable,
  input  logic [ADDR_W-1:0]    ic_addr,
  output logic [INSTR_LEN-1:0] ic_instr,
  output logic                 ic_success,
  input  logic                 ls_enable,
  input  logic                 ls_wr,
  input  logic [ADDR_W-1:0]    ls_addr,
  input  logic [2:0]           ls_len,
  input  logic [31:0]          ls_wdata,
  output logic [31:0]          ls_rdata,
  output logic                 ls_success
);

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          base_q, base_d;
  logic [ADDR_W-1:0]          mem_a_q, mem_a_d;
  logic [2:0]                 len_q, len_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [2:0]                 iss_q, iss_d;
  logic [3:0][BYTE_LEN-1:0]   wdata_q, wdata_d;
  logic [3:0][BYTE_LEN-1:0]   lane_q, lane_d;
  logic [1:0]                 vld_pipe_q, vld_pipe_d;
  logic [BYTE_LEN-1:0]        dout_q, dout_d;
  logic                       wr_q, wr_d;
  logic                       is_ic_q, is_ic_d;
  logic                       ic_succ_q, ic_succ_d;
  logic                       ls_succ_q, ls_succ_d;
  logic [INSTR_LEN-1:0]       ic_instr_q, ic_instr_d;
  logic [31:0]                ls_rdata_q, ls_rdata_d;

  logic [ADDR_W-1:0]          cur_addr;
  logic [ADDR_W-1:0]          iss_addr;
  logic                       io_stall;

  assign cur_addr = base_q + {{(ADDR_W-3){1'b0}}, cnt_q};
  assign iss_addr = base_q + {{(ADDR_W-3){1'b0}}, iss_q};
  assign io_stall = ((cur_addr & IO_ADDR) == IO_ADDR) && io_buffer_full;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mem_a_d    = mem_a_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    iss_d      = iss_q;
    wdata_d    = wdata_q;
    lane_d     = lane_q;
    vld_pipe_d = vld_pipe_q;
    dout_d     = dout_q;
    wr_d       = FALSE;
    is_ic_d    = is_ic_q;
    ic_succ_d  = FALSE;
    ls_succ_d  = FALSE;
    ic_instr_d = ic_instr_q;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      IDLE: begin
        vld_pipe_d = 2'b00;
        if (ls_enable) begin
          base_d  = ls_addr;
          mem_a_d = ls_addr;
          len_d   = norm_len(ls_len);
          wdata_d = ls_wdata;
          lane_d  = '0;
          cnt_d   = 3'd0;
          is_ic_d = FALSE;
          if (ls_wr) begin
            iss_d   = 3'd0;
            state_d = LS_WRITE;
          end else begin
            iss_d      = 3'd1;
            vld_pipe_d = 2'b01;
            state_d    = LS_READ;
          end
        end else if (ic_enable && !clr) begin
          base_d     = ic_addr;
          mem_a_d    = ic_addr;
          len_d      = 3'd4;
          lane_d     = '0;
          cnt_d      = 3'd0;
          iss_d      = 3'd1;
          vld_pipe_d = 2'b01;
          is_ic_d    = TRUE;
          state_d    = IC_READ;
        end
      end

      IC_READ, LS_READ: begin
        // RAM answers one cycle after the address, so each issued byte
        // becomes capturable two edges later.
        vld_pipe_d = {vld_pipe_q[0], 1'b0};
        if (iss_q < len_q) begin
          mem_a_d       = iss_addr;
          iss_d         = iss_q + 3'd1;
          vld_pipe_d[0] = 1'b1;
        end
        if (vld_pipe_q[1]) begin
          lane_d[cnt_q[1:0]] = mem_din;
          cnt_d              = cnt_q + 3'd1;
        end
        if (cnt_q == len_q) begin
          vld_pipe_d = 2'b00;
          state_d    = DONE;
          if (is_ic_q) begin
            ic_succ_d  = TRUE;
            ic_instr_d = lane_q;
          end else begin
            ls_succ_d  = TRUE;
            ls_rdata_d = lane_q;
          end
        end
        // A flush kills only instruction fetches; stores belong to the LSB.
        if (state_q == IC_READ && clr) begin
          vld_pipe_d = 2'b00;
          ic_succ_d  = FALSE;
          ic_instr_d = ic_instr_q;
          state_d    = IDLE;
        end
      end

      LS_WRITE: begin
        if (cnt_q == len_q) begin
          ls_succ_d = TRUE;
          state_d   = DONE;
        end else if (!io_stall) begin
          mem_a_d = cur_addr;
          dout_d  = wdata_q[cnt_q[1:0]];
          wr_d    = TRUE;
          cnt_d   = cnt_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      mem_a_q    <= '0;
      len_q      <= 3'd0;
      cnt_q      <= 3'd0;
      iss_q      <= 3'd0;
      wdata_q    <= '0;
      lane_q     <= '0;
      vld_pipe_q <= 2'b00;
      dout_q     <= '0;
      wr_q       <= FALSE;
      is_ic_q    <= FALSE;
      ic_succ_q  <= FALSE;
      ls_succ_q  <= FALSE;
      ic_instr_q <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      base_q     <= base_d;
      mem_a_q    <= mem_a_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      iss_q      <= iss_d;
      wdata_q    <= wdata_d;
      lane_q     <= lane_d;
      vld_pipe_q <= vld_pipe_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      is_ic_q    <= is_ic_d;
      ic_succ_q  <= ic_succ_d;
      ls_succ_q  <= ls_succ_d;
      ic_instr_q <= ic_instr_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = dout_q;
  assign mem_wr     = wr_q & rdy;
  assign ic_instr   = ic_instr_q;
  assign ic_success = ic_succ_q;
  assign ls_rdata   = ls_rdata_q;
  assign ls_success = ls_succ_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected responses, a
// negedge monitor pops and compares on every success pulse.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, mem_wr, io_buffer_full, clr;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        ic_enable, ic_success;
  logic [31:0] ic_addr, ic_instr;
  logic        ls_enable, ls_wr, ls_success;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_len;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .clr(clr),
    .ic_enable(ic_enable), .ic_addr(ic_addr), .ic_instr(ic_instr), .ic_success(ic_success),
    .ls_enable(ls_enable), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_success(ls_success)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // RAM model sharing the global enable; I/O region writes go to a log.
  logic [7:0] ram [0:4095];
  int         io_wr_cnt = 0;
  logic [7:0] io_last = 8'h00;
  int         wr_cycles = 0;
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) begin
        wr_cycles++;
        if (mem_a[17:16] == 2'b11) begin
          io_wr_cnt++;
          io_last = mem_dout;
        end else begin
          ram[mem_a[11:0]] <= mem_dout;
        end
      end
      mem_din <= ram[mem_a[11:0]];
    end
  end

  typedef struct {
    logic        is_ic;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ic_success || ls_success) begin
      chk("pulse_overlap", {31'd0, ic_success & ls_success}, 32'd0);
      chk("pulse_back_to_back", {31'd0, prev_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: ic=%0b ls=%0b with empty scoreboard", ic_success, ls_success);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_client", {31'd0, ic_success}, {31'd0, e.is_ic});
        if (e.chk_data) chk("pulse_data", ic_success ? ic_instr : ls_rdata, e.data);
      end
    end
    prev_pulse = ic_success | ls_success;
  end

  task automatic wait_pulse(input bit is_ic, output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (is_ic ? ic_success : ls_success) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL pulse_timeout: got no %s success expected one within 40 cycles", is_ic ? "ic" : "ls");
    end
  endtask

  task automatic do_ic(input logic [31:0] a, input logic [31:0] exp, input int lat, input string nm);
    int t0, t1;
    @(negedge clk);
    ic_enable = 1'b1; ic_addr = a; t0 = cyc;
    exp_q.push_back('{1'b1, 1'b1, exp});
    wait_pulse(1'b1, t1);
    ic_enable = 1'b0;
    if (t1 >= 0) chk({nm, "_latency"}, t1 - t0 - 1, lat);
    @(negedge clk);
    chk({nm, "_pulse_width"}, {31'd0, ic_success}, 32'd0);
  endtask

  task automatic do_ls(input bit wr, input logic [31:0] a, input logic [2:0] len,
                       input logic [31:0] d, input logic [31:0] exp, input int lat, input string nm);
    int t0, t1;
    @(negedge clk);
    ls_enable = 1'b1; ls_wr = wr; ls_addr = a; ls_len = len; ls_wdata = d; t0 = cyc;
    exp_q.push_back('{1'b0, !wr, exp});
    wait_pulse(1'b0, t1);
    ls_enable = 1'b0;
    if (t1 >= 0) chk({nm, "_latency"}, t1 - t0 - 1, lat);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, stall_wr, n;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    {ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]} = {8'h13, 8'h05, 8'hA0, 8'h00};
    {ram[12'h104], ram[12'h105], ram[12'h106], ram[12'h107]} = {8'h93, 8'h00, 8'h10, 8'h00};
    {ram[12'h000], ram[12'h001], ram[12'h002], ram[12'h003]} = {8'hB7, 8'h12, 8'h34, 8'h00};
    ram[12'h010] = 8'hA5;

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; clr = 1'b0;
    ic_enable = 1'b0; ic_addr = '0;
    ls_enable = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_len = 3'd1; ls_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_ic_success", {31'd0, ic_success}, 32'd0);
    chk("rst_ls_success", {31'd0, ls_success}, 32'd0);
    chk("rst_ic_instr", ic_instr, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    rst = 1'b0;

    // Plain fetch
    do_ic(32'h100, 32'h00A00513, 6, "ic_fetch");

    // Store word, then halfword load from its upper half
    wr_cycles = 0;
    do_ls(1'b1, 32'h200, 3'd4, 32'hDEADBEEF, 32'h0, 5, "sw");
    chk("sw_wr_cycles", wr_cycles, 4);
    chk("sw_byte0", {24'd0, ram[12'h200]}, 32'hEF);
    chk("sw_byte1", {24'd0, ram[12'h201]}, 32'hBE);
    chk("sw_byte2", {24'd0, ram[12'h202]}, 32'hAD);
    chk("sw_byte3", {24'd0, ram[12'h203]}, 32'hDE);
    do_ls(1'b0, 32'h202, 3'd2, 32'h0, 32'h0000DEAD, 4, "lh");

    // Zero extension and odd length treated as a word
    do_ls(1'b0, 32'h010, 3'd1, 32'h0, 32'h000000A5, 3, "lb");
    do_ls(1'b0, 32'h101, 3'd3, 32'h0, 32'h9300A005, 6, "len3_unaligned");

    // Contention: LS first, IC after DONE + IDLE
    @(negedge clk);
    ic_enable = 1'b1; ic_addr = 32'h0;
    ls_enable = 1'b1; ls_wr = 1'b0; ls_addr = 32'h10; ls_len = 3'd1;
    t0 = cyc;
    exp_q.push_back('{1'b0, 1'b1, 32'h000000A5});
    exp_q.push_back('{1'b1, 1'b1, 32'h003412B7});
    wait_pulse(1'b0, t1);
    ls_enable = 1'b0;
    if (t1 >= 0) chk("contend_ls_latency", t1 - t0 - 1, 3);
    wait_pulse(1'b1, t2);
    ic_enable = 1'b0;
    if (t1 >= 0 && t2 >= 0) chk("contend_ic_gap", t2 - t1, 8);
    @(negedge clk);

    // I/O store held off by a full UART buffer
    io_wr_cnt = 0; stall_wr = 0;
    @(negedge clk);
    io_buffer_full = 1'b1;
    ls_enable = 1'b1; ls_wr = 1'b1; ls_addr = 32'h30000; ls_len = 3'd1; ls_wdata = 32'hFFFFFF41;
    exp_q.push_back('{1'b0, 1'b0, 32'h0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_wr) stall_wr++;
    end
    io_buffer_full = 1'b0; t0 = cyc;
    wait_pulse(1'b0, t1);
    ls_enable = 1'b0;
    if (t1 >= 0) chk("io_release_latency", t1 - t0, 2);
    chk("io_stall_writes", stall_wr, 0);
    chk("io_write_count", io_wr_cnt, 1);
    chk("io_write_data", {24'd0, io_last}, 32'h41);
    @(negedge clk);

    // Flush mid-fetch, then a fetch issued the very next cycle
    @(negedge clk);
    ic_enable = 1'b1; ic_addr = 32'h100;
    repeat (3) @(negedge clk);
    clr = 1'b1; ic_enable = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    chk("flush_mem_wr", {31'd0, mem_wr}, 32'd0);
    ic_enable = 1'b1; ic_addr = 32'h104; t0 = cyc;
    exp_q.push_back('{1'b1, 1'b1, 32'h00100093});
    wait_pulse(1'b1, t1);
    ic_enable = 1'b0;
    if (t1 >= 0) chk("flush_refetch_latency", t1 - t0 - 1, 6);
    @(negedge clk);

    // Reset in the middle of a store
    @(negedge clk);
    ls_enable = 1'b1; ls_wr = 1'b1; ls_addr = 32'h300; ls_len = 3'd4; ls_wdata = 32'h11223344;
    repeat (2) @(negedge clk);
    chk("rst_mid_pre_wr", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1; ls_enable = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mid_mem_a", mem_a, 32'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ls_success) n++;
    end
    chk("rst_mid_no_success", n, 0);

    // rdy low for three cycles during a fetch
    @(negedge clk);
    ic_enable = 1'b1; ic_addr = 32'h100; t0 = cyc;
    exp_q.push_back('{1'b1, 1'b1, 32'h00A00513});
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    rdy = 1'b1;
    wait_pulse(1'b1, t1);
    ic_enable = 1'b0;
    if (t1 >= 0) chk("rdy_stall_latency", t1 - t0 - 1, 9);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the byte-wide unified RAM and the core's two memory clients: the instruction cache (32-bit fetch) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises every access into byte cycles.
- Arbitrates between the two clients and returns each result with a one-cycle success pulse.
- Is the responder to the ICache's mem_enable/mem_addr request and drives mem_instr/mem_fetch_success back to it.

Parameters:
- ADDR_W, 32, address width.
- IO_ADDR, 32'h30000, lowest address of the memory-mapped I/O region (address bits [17:16]==2'b11).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- mem_din  in  8  RAM read data, valid one cycle after its address is driven
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  UART buffer full; stalls I/O writes
- clr  in  1  pipeline flush; aborts an in-flight ICache read
- ic_enable  in  1  ICache request, held until ic_success
- ic_addr  in  32  fetch address
- ic_instr  out  32  fetched instruction, little-endian
- ic_success  out  1  one-cycle pulse; ic_instr valid
- ls_enable  in  1  LSB request, held until ls_success
- ls_wr  in  1  1 = store
- ls_addr  in  32  byte address
- ls_len  in  3  byte count: 1, 2 or 4
- ls_wdata  in  32  store data; low ls_len bytes used
- ls_rdata  out  32  load data, zero-extended
- ls_success  out  1  one-cycle pulse

Behaviour:
- Reset: the synchronous, active-high reset on rst forces the following on the next clk edge:
  - state = IDLE
  - mem_a = 0, mem_dout = 0, mem_wr = 0
  - ic_success = 0, ls_success = 0
  - ic_instr = 0, ls_rdata = 0
  - byte counter = 0
- Reset mid-transfer: abandons the transfer; no success pulse is issued.
- rdy low: all registers hold; mem_wr is forced to 0 that cycle.
- States: IDLE, IC_READ, LS_READ, LS_WRITE, DONE.
- IDLE:
  - ls_enable takes priority over ic_enable.
  - The request is latched: address, length, write data, and cnt = 0.
  - mem_a <= request address.
  - Go to LS_READ, LS_WRITE or IC_READ.
- Read states:
  - Each cycle, mem_a <= base + cnt + 1 while issued < len.
  - mem_din from the previous cycle is stored into byte lane cnt.
  - After byte len-1 is captured, the success pulse and data are registered and the block goes to DONE.
  - Latency is len+2 cycles from the accepting edge to the success pulse: ICache = 6, lb = 3.
- Write state:
  - Each cycle, mem_a = base + cnt, mem_dout = byte cnt, mem_wr = 1.
  - After len bytes, mem_wr <= 0, ls_success pulses, go to DONE.
  - Latency is len+1 cycles.
- I/O write stall:
  - Applies when the address is in the I/O region and io_buffer_full = 1.
  - The write byte is not issued (mem_wr = 0) and cnt holds until io_buffer_full = 0.
  - Total latency grows by the stall cycles.
- DONE:
  - One cycle.
  - Requests are ignored so the client can drop its enable.
  - Success outputs return to 0.
  - Next state is IDLE.
- clr:
  - IC_READ or DONE-after-IC: go to IDLE next cycle, no ic_success, mem_wr = 0.
  - LS states: no effect; the LSB owns store commit.
  - clr in IDLE: an ic_enable in the same cycle is not accepted.
- Address arithmetic is 32-bit wrap-around. Unaligned addresses are legal, bytes are consecutive.
- ls_len values other than 1, 2 or 4 are treated as 4.
- Load data is zero-extended; sign extension is the LSB's job.
- Simultaneous ic_enable and ls_enable: the LS request is served first. The ICache request stays pending and is accepted in the IDLE after DONE.
- Success pulses are never asserted in two consecutive cycles; the two clients' pulses are never asserted together.

Decomposition:
- Shared define package:
  - ADDR/INSTRLEN/BYTE widths
  - TRUE/FALSE
  - IO_ADDR
  - state encodings for mem_ctrl
- No sub-module: the byte-lane assembly is a 4-entry register indexed by cnt and stays inline.

Test Plan:
- ICache fetch: RAM[0x100..0x103] = 13 05 A0 00, ic_enable with ic_addr = 0x100 -> ic_success on cycle 6 after accept, ic_instr = 0x00A00513, one-cycle pulse.
- Store word then load half:
  - sw 0xDEADBEEF at 0x200 -> mem_wr high 4 cycles at 0x200..0x203 with bytes EF BE AD DE, ls_success at cycle 5.
  - lh 0x202 -> ls_rdata = 0x0000DEAD at cycle 4.
- Contention: ic_enable (0x0) and ls_enable (lb 0x10) asserted in the same cycle -> ls_success first (cycle 3), DONE, then IC accepted, ic_success 6 cycles later; pulses never overlap.
- I/O stall: sb 0x41 to 0x30000 with io_buffer_full = 1 for 5 cycles -> mem_wr = 0 throughout the stall, then a single write of 0x41, ls_success 2 cycles after full drops.
- Flush: clr on cycle 3 of an IC_READ -> no ic_success; IDLE next cycle; a new fetch at 0x104 completes normally in 6 cycles.
- Reset/rdy:
  - rst mid LS_WRITE -> mem_wr = 0 and state IDLE next edge, no ls_success.
  - rdy low for 3 cycles mid-read -> latency extends by exactly 3, data correct.
